// File: rtl/rr_arb_n.sv
// rr_arb_n: N-way round-robin arbiter with a registered grant and an ack handshake.
//
// Handshake: the grant (gnt_vld/gnt_onehot/gnt_num) is a registered level.
// It is asserted one cycle after an arbitration. It stays frozen until the
// winner pulses gnt_ack. An ack moves the pointer past the winner. If
// req_vld & |req is also true on the ack cycle, the next grant is issued
// back-to-back without an idle cycle. gnt_ack is ignored while no grant is held.
//
// Ports:
//   clks        in   1         clock
//   reset       in   1         synchronous active-high reset
//   req         in   REQ_W     per-channel request, bit i = channel i
//   req_vld     in   1         arbitration strobe; req sampled only when high
//   gnt_ack     in   1         winner done; releases the grant
//   gnt_vld     out  1         grant valid
//   gnt_onehot  out  REQ_W     one-hot grant, zero when gnt_vld=0
//   gnt_num     out  RR_NUM_W  binary winner index, holds last winner when idle
//   rr_bit      out  RR_NUM_W  priority pointer (highest-priority channel next)
//   fsm_state   out  1         debug view of the FSM (0 = IDLE, 1 = BUSY)
module rr_arb_n #(
    parameter int REQ_W    = 8,
    parameter int RR_NUM_W = 3
) (
    input  logic                clks,
    input  logic                reset,
    input  logic [REQ_W-1:0]    req,
    input  logic                req_vld,
    input  logic                gnt_ack,
    output logic                gnt_vld,
    output logic [REQ_W-1:0]    gnt_onehot,
    output logic [RR_NUM_W-1:0] gnt_num,
    output logic [RR_NUM_W-1:0] rr_bit,
    output logic                fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;

    logic [RR_NUM_W-1:0] next_ptr;
    logic [RR_NUM_W-1:0] arb_ptr;
    logic                hi_found;
    logic [RR_NUM_W-1:0] hi_win;
    logic [RR_NUM_W-1:0] lo_win;
    logic [RR_NUM_W-1:0] win;
    logic [REQ_W-1:0]    win_onehot;
    logic                arb_ok;

    // Pointer after an ack. The wrap compares against the last channel, so
    // non-power-of-two channel counts never see an out-of-range pointer.
    assign next_ptr = (gnt_num == RR_NUM_W'(REQ_W - 1)) ? '0 : gnt_num + 1'b1;

    // On an ack cycle, a same-cycle arbitration must use the post-ack pointer.
    // The acked channel then ends up at lowest priority.
    assign arb_ptr = (state == BUSY && gnt_ack) ? next_ptr : rr_bit;

    assign arb_ok = req_vld && (|req);

    // The search is done in two halves.
    // hi_win is the lowest requesting index at or above the pointer.
    // lo_win is the lowest requesting index overall; it is used when the
    // search wraps around.
    // Both loops run downward, so the last match is the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_win = RR_NUM_W'(i);
                if (i >= int'(arb_ptr)) begin
                    hi_found = 1'b1;
                    hi_win   = RR_NUM_W'(i);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < REQ_W; i++) begin
            win_onehot[i] = (win == RR_NUM_W'(i));
        end
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state      <= IDLE;
            gnt_vld    <= 1'b0;
            gnt_onehot <= '0;
            gnt_num    <= '0;
            rr_bit     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Granting from idle leaves the pointer where it is.
                    if (arb_ok) begin
                        state      <= BUSY;
                        gnt_vld    <= 1'b1;
                        gnt_onehot <= win_onehot;
                        gnt_num    <= win;
                    end
                end
                BUSY: begin
                    // Without an ack everything stays frozen, even if the
                    // winner drops its request.
                    if (gnt_ack) begin
                        rr_bit <= next_ptr;
                        if (arb_ok) begin
                            gnt_onehot <= win_onehot;
                            gnt_num    <= win;
                        end else begin
                            state      <= IDLE;
                            gnt_vld    <= 1'b0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    gnt_vld    <= 1'b0;
                    gnt_onehot <= '0;
                end
            endcase
        end
    end

    assign fsm_state = (state == BUSY);

endmodule

// File: tb/tb_rr_arb_n.sv
// Bench for rr_arb_n.
// One instance has 8 channels and another has 5 channels (non-power-of-two).
// A behavioural model predicts each cycle's outputs when the inputs are driven.
// The prediction is queued and compared after the clock edge.
module tb_rr_arb_n;

    logic       clks;
    logic       reset;

    logic [7:0] req8;
    logic       vld8;
    logic       ack8;
    logic       gnt_vld8;
    logic [7:0] gnt_onehot8;
    logic [2:0] gnt_num8;
    logic [2:0] rr_bit8;
    logic       fsm8;

    logic [4:0] req5;
    logic       vld5;
    logic       ack5;
    logic       gnt_vld5;
    logic [4:0] gnt_onehot5;
    logic [2:0] gnt_num5;
    logic [2:0] rr_bit5;
    logic       fsm5;

    rr_arb_n #(.REQ_W(8), .RR_NUM_W(3)) dut8 (
        .clks       (clks),
        .reset      (reset),
        .req        (req8),
        .req_vld    (vld8),
        .gnt_ack    (ack8),
        .gnt_vld    (gnt_vld8),
        .gnt_onehot (gnt_onehot8),
        .gnt_num    (gnt_num8),
        .rr_bit     (rr_bit8),
        .fsm_state  (fsm8)
    );

    rr_arb_n #(.REQ_W(5), .RR_NUM_W(3)) dut5 (
        .clks       (clks),
        .reset      (reset),
        .req        (req5),
        .req_vld    (vld5),
        .gnt_ack    (ack5),
        .gnt_vld    (gnt_vld5),
        .gnt_onehot (gnt_onehot5),
        .gnt_num    (gnt_num5),
        .rr_bit     (rr_bit5),
        .fsm_state  (fsm5)
    );

    // Clock / reset
    initial clks = 1'b0;
    always #5 clks = ~clks;

    // Scoreboard: {fsm, gnt_vld, onehot[7:0], gnt_num[2:0], rr_bit[2:0]}
    logic [15:0] exp_q8[$];
    logic [15:0] exp_q5[$];
    int          m_busy[2];
    int          m_num[2];
    int          m_ptr[2];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic int pick(input int w, input int ptr, input logic [7:0] r);
        int idx;
        for (int k = 0; k < w; k++) begin
            idx = (ptr + k) % w;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // Model one cycle for instance d (0 = 8-way, 1 = 5-way) and queue the result.
    task automatic model(input int d, input int w, input logic [7:0] r,
                         input logic v, input logic a, input logic rst);
        logic [7:0]  oh;
        logic [15:0] e;
        if (rst) begin
            m_busy[d] = 0; m_num[d] = 0; m_ptr[d] = 0;
        end else if (m_busy[d] == 0) begin
            if (v && r != 8'h0) begin
                m_busy[d] = 1;
                m_num[d]  = pick(w, m_ptr[d], r);
            end
        end else if (a) begin
            m_ptr[d] = (m_num[d] == w - 1) ? 0 : m_num[d] + 1;
            if (v && r != 8'h0) m_num[d] = pick(w, m_ptr[d], r);
            else                m_busy[d] = 0;
        end
        oh = (m_busy[d] != 0) ? 8'(1 << m_num[d]) : 8'h0;
        e  = {1'(m_busy[d]), 1'(m_busy[d]), oh, 3'(m_num[d]), 3'(m_ptr[d])};
        if (d == 0) exp_q8.push_back(e);
        else        exp_q5.push_back(e);
    endtask

    // Driver: inputs are already set; predict, clock, then compare.
    task automatic step();
        logic [15:0] e;
        model(0, 8, req8, vld8, ack8, reset);
        model(1, 5, {3'b000, req5}, vld5, ack5, reset);
        @(posedge clks);
        #1;
        if (exp_q8.size() == 0) check("q8_empty", 32'd1, 32'd0);
        else begin
            e = exp_q8.pop_front();
            check("d8_fsm",    fsm8,        e[15]);
            check("d8_vld",    gnt_vld8,    e[14]);
            check("d8_onehot", gnt_onehot8, e[13:6]);
            check("d8_num",    gnt_num8,    e[5:3]);
            check("d8_rr_bit", rr_bit8,     e[2:0]);
        end
        if (exp_q5.size() == 0) check("q5_empty", 32'd1, 32'd0);
        else begin
            e = exp_q5.pop_front();
            check("d5_fsm",    fsm5,        e[15]);
            check("d5_vld",    gnt_vld5,    e[14]);
            check("d5_onehot", gnt_onehot5, e[10:6]);
            check("d5_num",    gnt_num5,    e[5:3]);
            check("d5_rr_bit", rr_bit5,     e[2:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        req8 = '0; vld8 = 1'b0; ack8 = 1'b0;
        req5 = '0; vld5 = 1'b0; ack5 = 1'b0;
        step();
        step();
        check("rst_vld",    gnt_vld8,    32'd0);
        check("rst_onehot", gnt_onehot8, 32'd0);
        check("rst_rr_bit", rr_bit8,     32'd0);
        reset = 1'b0;

        // All channels requesting, every grant acked: 0..7 then 0.
        req8 = 8'hFF; vld8 = 1'b1; ack8 = 1'b0;
        step();
        check("t1_first", gnt_num8, 32'd0);
        ack8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t1_num", gnt_num8, 32'(k % 8));
            check("t1_vld", gnt_vld8, 32'd1);
        end

        // Only channels 0 and 7 requesting, immediate acks.
        req8 = 8'b1000_0001;
        step();
        check("t2_num_a", gnt_num8, 32'd7);
        check("t2_ptr_a", rr_bit8,  32'd1);
        step();
        check("t2_num_b", gnt_num8, 32'd0);
        check("t2_ptr_b", rr_bit8,  32'd0);
        step();
        check("t2_num_c", gnt_num8, 32'd7);

        // Release to idle, pointer wraps to 0 past channel 7.
        req8 = 8'h00;
        step();
        check("t2_idle", gnt_vld8, 32'd0);
        check("t2_wrap", rr_bit8,  32'd0);

        // Grant 3 and hold it while inputs churn.
        req8 = 8'h08; vld8 = 1'b1; ack8 = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            req8 = 8'($urandom_range(0, 255));
            vld8 = 1'($urandom_range(0, 1));
            step();
            check("t3_num",    gnt_num8,    32'd3);
            check("t3_onehot", gnt_onehot8, 32'h08);
            check("t3_rr_bit", rr_bit8,     32'd0);
        end
        req8 = 8'h00; ack8 = 1'b1;
        step();
        check("t3_ptr",    rr_bit8,     32'd4);
        check("t4_vld",    gnt_vld8,    32'd0);
        check("t4_onehot", gnt_onehot8, 32'd0);
        check("t4_fsm",    fsm8,        32'd0);

        // Stray ack while idle, and req_vld with no requests.
        vld8 = 1'b0;
        step();
        vld8 = 1'b1;
        step();
        check("t4_stray_vld", gnt_vld8, 32'd0);
        check("t4_stray_ptr", rr_bit8,  32'd4);
        check("t4_stray_num", gnt_num8, 32'd3);

        // Reset in the middle of a grant on channel 5.
        ack8 = 1'b0; req8 = 8'h20;
        step();
        check("t5_num", gnt_num8, 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_rst_vld", gnt_vld8, 32'd0);
        check("t5_rst_ptr", rr_bit8,  32'd0);
        req8 = 8'h21;
        step();
        check("t5_after", gnt_num8, 32'd0);
        ack8 = 1'b1; req8 = 8'h00;
        step();

        // Five channels, channels 0 and 4 requesting.
        req5 = 5'b10001; vld5 = 1'b1; ack5 = 1'b0;
        step();
        check("t6_num0", gnt_num5, 32'd0);
        ack5 = 1'b1;
        step();
        check("t6_num1", gnt_num5, 32'd4);
        step();
        check("t6_num2", gnt_num5, 32'd0);
        check("t6_wrap", rr_bit5,  32'd0);
        step();
        check("t6_num3", gnt_num5, 32'd4);

        // Random traffic on both instances, checked by the model.
        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(0, 40) == 0);
            req8  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) req8 = 8'h00;
            vld8  = ($urandom_range(0, 3) != 0);
            ack8  = ($urandom_range(0, 1) == 1);
            req5  = 5'($urandom_range(0, 31));
            vld5  = ($urandom_range(0, 3) != 0);
            ack5  = ($urandom_range(0, 1) == 1);
            step();
        end
        reset = 1'b0;

        // Fairness: all requesting, every grant acked.
        req8 = 8'hFF; vld8 = 1'b1; ack8 = 1'b1;
        step();
        for (int k = 0; k < 16; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
